// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Purpose:
//   Bit-serial unsigned subtractor. It computes diff = a - b over WIDTH clock
//   cycles, one bit per cycle, starting with the LSB.
//   Each bit is resolved by two cascaded half-subtractor stages:
//     - the first stage takes the operand bits;
//     - the second stage takes the incoming borrow.
//   The two stage borrows are ORed together. A borrow flip-flop carries the
//   result from one bit to the next.
//
// Ports:
//   clk     in   1      single clock, rising edge
//   rst     in   1      synchronous, active-high reset (priority over all)
//   start   in   1      operation request, sampled only while idle
//   a       in   WIDTH  minuend, captured on the accepting edge
//   b       in   WIDTH  subtrahend, captured on the accepting edge
//   busy    out  1      high while an operation is in flight (SHIFT or DONE)
//   done    out  1      one-cycle pulse; diff/borrow are valid from this cycle
//   diff    out  WIDTH  (a - b) mod 2^WIDTH, held until the next completion
//   borrow  out  1      1 iff a < b (unsigned)
//
// Timing:
//   If start is accepted at edge E0, done is high between edge E0+WIDTH and
//   edge E0+WIDTH+1. The earliest next accept is at edge E0+WIDTH+2.
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Half-subtractor cell: returns {borrow, difference} for x - y.
    function automatic logic [1:0] half_sub(input logic x, input logic y);
        return {~x & y, x ^ y};
    endfunction

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             bin_q,    bin_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;

    // Per-bit datapath: two half-subtractor stages plus an OR for the borrow.
    logic [1:0]       hs1, hs2;
    logic             bit_d, bit_bout;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        hs1      = half_sub(a_sr_q[0], b_sr_q[0]);
        hs2      = half_sub(hs1[0], bin_q);
        bit_d    = hs2[0];
        bit_bout = hs1[1] | hs2[1];
        res_next = {bit_d, res_sr_q[WIDTH-1:1]};
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so that no path through
        // the case statement leaves one unassigned (which would infer a latch).
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    res_sr_d = '0;
                    bin_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_next;
                bin_d    = bit_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                // The last bit is being resolved this cycle. Publish the full
                // vector straight from the datapath, so the result does not lag
                // one cycle behind res_sr.
                if (cnt_q == CNT_LAST) begin
                    diff_d   = res_next;
                    borrow_d = bit_bout;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    // Status outputs decode the state register directly, so no input reaches
    // an output combinationally.
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Purpose:
//   Self-checking bench for serial_subtractor with WIDTH = 8.
//   Inputs are driven and outputs are sampled 1 ns after each rising edge.
//
// Ports:
//   none (top-level bench)
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    int n_tests = 0;
    int n_fail  = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one operation from IDLE.
    // If glitch_at > 0, a disturbing request (start=1, a=FF, b=00) is driven
    // during cycle glitch_at after the accepting edge. That request must be
    // ignored.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_diff, input logic exp_borrow,
                          input int glitch_at);
        int cycles;
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();                       // accepting edge E0
        start = 1'b0;
        a     = ~av;                  // operands changing after E0 must not matter
        b     = ~bv;
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            if (cycles + 1 == glitch_at) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'h00;
            end else begin
                start = 1'b0;
            end
            tick();
            cycles++;
        end
        start = 1'b0;
        check({tag, " done latency"}, 32'(cycles), 32'(W));
        check({tag, " diff"},         32'(diff),   32'(exp_diff));
        check({tag, " borrow"},       32'(borrow), 32'(exp_borrow));
        tick();                       // DONE -> IDLE
        check({tag, " done one cycle"}, 32'(done), 32'd0);
        check({tag, " idle after"},     32'(busy), 32'd0);
        check({tag, " diff held"},      32'(diff), 32'(exp_diff));
    endtask

    initial begin
        logic [W-1:0] cur_a, cur_b, nxt_a, nxt_b;
        logic [W:0]   ref_res;
        int           done_seen;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // 1. Reset held for two cycles.
        tick();
        tick();
        check("reset busy",   32'(busy),   32'd0);
        check("reset done",   32'(done),   32'd0);
        check("reset diff",   32'(diff),   32'h00);
        check("reset borrow", 32'(borrow), 32'd0);
        rst = 1'b0;
        tick();
        check("idle without start", 32'(busy), 32'd0);

        // 2./3. Directed vectors, including the boundary cases.
        run_op("35-12", 8'h35, 8'h12, 8'h23, 1'b0, 0);
        run_op("00-01", 8'h00, 8'h01, 8'hFF, 1'b1, 0);
        run_op("AA-AA", 8'hAA, 8'hAA, 8'h00, 1'b0, 0);
        run_op("00-FF", 8'h00, 8'hFF, 8'h01, 1'b1, 0);
        run_op("FF-00", 8'hFF, 8'h00, 8'hFF, 1'b0, 0);
        run_op("80-7F", 8'h80, 8'h7F, 8'h01, 1'b0, 0);

        // 4. start asserted at E0+3 while busy is ignored.
        run_op("start while busy", 8'h35, 8'h12, 8'h23, 1'b0, 3);
        tick();
        check("ignored start not queued", 32'(busy), 32'd0);

        // 5. Reset at E0+4 abandons the operation.
        a     = 8'h35;
        b     = 8'h12;
        start = 1'b1;
        tick();                       // E0
        start = 1'b0;
        tick();
        tick();
        tick();                       // E0+3
        rst = 1'b1;
        tick();                       // E0+4, reset sampled
        check("mid-op reset busy",   32'(busy),   32'd0);
        check("mid-op reset diff",   32'(diff),   32'h00);
        check("mid-op reset borrow", 32'(borrow), 32'd0);
        check("mid-op reset done",   32'(done),   32'd0);
        rst       = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        check("no done after reset", 32'(done_seen), 32'd0);
        run_op("after reset", 8'h5A, 8'h3C, 8'h1E, 1'b0, 0);

        // 6. start tied high: back-to-back operations every W+2 cycles.
        cur_a = 8'($urandom);
        cur_b = 8'($urandom);
        a     = cur_a;
        b     = cur_b;
        start = 1'b1;
        tick();                       // first accept
        for (int v = 0; v < 1000; v++) begin
            nxt_a = 8'($urandom);
            nxt_b = 8'($urandom);
            a     = nxt_a;            // changes mid-operation; sampled only at next accept
            b     = nxt_b;
            repeat (W - 1) tick();
            check("b2b done early", 32'(done), 32'd0);
            tick();                   // E0+W
            ref_res = {1'b0, cur_a} - {1'b0, cur_b};
            check("b2b done",   32'(done),   32'd1);
            check("b2b diff",   32'(diff),   32'(ref_res[W-1:0]));
            check("b2b borrow", 32'(borrow), 32'(cur_a < cur_b));
            tick();                   // E0+W+1: back to IDLE
            check("b2b idle gap", 32'(busy), 32'd0);
            tick();                   // E0+W+2: next accept
            cur_a = nxt_a;
            cur_b = nxt_b;
        end
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog: if it fires, the run is stopped immediately.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
